// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants, command/state encodings and helpers for the framed UART loader.
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [7:0] {
        CMD_WR_INSN = 8'h01,
        CMD_WR_DATA = 8'h02,
        CMD_RUN     = 8'h03,
        CMD_HALT    = 8'h04
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        LEN,
        PAYLOAD,
        CHK,
        RESP
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return b >= 8'h01 && b <= 8'h04;
    endfunction

    function automatic logic is_wr(input logic [7:0] b);
        return b == CMD_WR_INSN || b == CMD_WR_DATA;
    endfunction

endpackage

// File: rtl/uart_loader_word_pack.sv
// uart_loader_word_pack: packs 4 little-endian bytes into a word; word_valid is high with the 4th byte.
module uart_loader_word_pack
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sr;
    logic [1:0]  idx;

    assign word       = {byte_in, sr};
    assign word_valid = byte_valid && idx == 2'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (byte_valid) begin
            idx <= idx + 2'd1;
            sr  <= {byte_in, sr[23:8]};
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: framed host loader (SYNC/CMD/ADDR/LEN/payload/CHK) driving core memory writes and run control.
// Define UART_LOADER_CHK_EN to expect and verify the trailing XOR checksum byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int RUN_DELAY      = 100,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_WORDS      = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_rd,
    input  logic [7:0]  rx_byte,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        run,
    output logic        ack_valid,
    output logic [7:0]  ack_byte,
    output logic        busy,
    output logic        err
);

`ifdef UART_LOADER_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_e      state, state_n, post;
    logic        rx_rd_q, acc, nak_n, resp_nak, expire, wv, enter_resp, frame_ok, pend;
    logic [7:0]  cmd_q, fcmd, chk, len_lo;
    logic [1:0]  idx;
    logic [15:0] words_left, len_full;
    logic [31:0] addr_ptr, word, to_cnt, dly;

    assign acc        = rx_rd & ~rx_rd_q;
    assign len_full   = {rx_byte, len_lo};
    assign fcmd       = (state == CMD) ? rx_byte : cmd_q;
    assign post       = CHK_EN ? CHK : RESP;
    assign expire     = state != IDLE && state != RESP && !acc && to_cnt == 32'(TIMEOUT_CYCLES - 1);
    assign enter_resp = state_n == RESP && state != RESP;
    assign frame_ok   = enter_resp && !nak_n;

    uart_loader_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != PAYLOAD),
        .byte_valid (acc && state == PAYLOAD),
        .byte_in    (rx_byte),
        .word       (word),
        .word_valid (wv)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        nak_n   = 1'b0;
        case (state)
            IDLE:    state_n = (acc && rx_byte == SYNC_BYTE) ? CMD : IDLE;
            CMD: if (acc) begin
                nak_n   = !is_cmd(rx_byte);
                state_n = nak_n ? RESP : is_wr(rx_byte) ? ADDR : post;
            end
            ADDR:    state_n = (acc && idx == 2'd3) ? LEN : ADDR;
            LEN: if (acc && idx[0]) begin
                nak_n   = 32'(len_full) > 32'(MAX_WORDS);
                state_n = nak_n ? RESP : (len_full == 16'd0) ? post : PAYLOAD;
            end
            PAYLOAD: state_n = (wv && words_left == 16'd1) ? post : PAYLOAD;
            CHK: if (acc) begin
                state_n = RESP;
                nak_n   = rx_byte != chk;
            end
            default: state_n = IDLE;
        endcase
        // A byte arriving in the expiry cycle keeps expire low, so it wins.
        if (expire) begin
            state_n = RESP;
            nak_n   = 1'b1;
        end
    end

    always_comb begin
        busy      = state != IDLE;
        ack_valid = state == RESP;
        ack_byte  = (state == RESP) ? (resp_nak ? NAK_BYTE : ACK_BYTE) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rd_q    <= 1'b0;
            cmd_q      <= '0;
            chk        <= '0;
            len_lo     <= '0;
            idx        <= '0;
            words_left <= '0;
            addr_ptr   <= '0;
            to_cnt     <= '0;
            dly        <= '0;
            pend       <= 1'b0;
            run        <= 1'b0;
            resp_nak   <= 1'b0;
            err        <= 1'b0;
            insn_we    <= 1'b0;
            data_we    <= 1'b0;
            insn_addr  <= '0;
            insn_din   <= '0;
            data_addr  <= '0;
            data_din   <= '0;
        end else begin
            rx_rd_q <= rx_rd;
            to_cnt  <= (acc || state == IDLE) ? 32'd0 : to_cnt + 32'd1;
            idx     <= (state_n != state) ? 2'd0 : idx + 2'(acc);
            insn_we <= wv && cmd_q == CMD_WR_INSN;
            data_we <= wv && cmd_q == CMD_WR_DATA;
            if (acc && state == IDLE && rx_byte == SYNC_BYTE) begin
                chk <= '0;
                err <= 1'b0;
            end
            if (acc && state inside {CMD, ADDR, LEN, PAYLOAD})
                chk <= chk ^ rx_byte;
            if (acc && state == CMD)
                cmd_q <= rx_byte;
            if (acc && state == ADDR)
                addr_ptr <= (idx == 2'd3) ? {rx_byte, addr_ptr[31:10], 2'b00} : {rx_byte, addr_ptr[31:8]};
            if (acc && state == LEN) begin
                len_lo     <= rx_byte;
                words_left <= len_full;
            end
            if (wv) begin
                words_left <= words_left - 16'd1;
                addr_ptr   <= addr_ptr + 32'd4;
                if (cmd_q == CMD_WR_INSN) begin
                    insn_addr <= addr_ptr;
                    insn_din  <= word;
                end else begin
                    data_addr <= addr_ptr;
                    data_din  <= word;
                end
            end
            if (enter_resp) begin
                resp_nak <= nak_n;
                if (nak_n)
                    err <= 1'b1;
            end
            // Loading memory always stops the core and cancels a pending start.
            if (acc && state == CMD && is_wr(rx_byte)) begin
                run  <= 1'b0;
                pend <= 1'b0;
            end else if (frame_ok && fcmd == CMD_RUN) begin
                pend <= 1'b1;
                dly  <= 32'(RUN_DELAY - 1);
            end else if (frame_ok && fcmd == CMD_HALT) begin
                run  <= 1'b0;
                pend <= 1'b0;
            end else if (pend) begin
                dly <= dly - 32'd1;
                if (dly <= 32'd1) begin
                    run  <= 1'b1;
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: table vectors, hand-written timing sequences and random frames against a frame-level model.
module tb_uart_loader;

    localparam int D  = 100;
    localparam int TO = 200;
    localparam int MW = 16384;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
`ifdef UART_LOADER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct {bit ins; logic [31:0] a; logic [31:0] d; int c;} wr_t;
    typedef struct {
        logic [7:0] cmd; logic [31:0] addr; int len; logic [31:0] w0; logic [31:0] w1; bit bad;
        logic [7:0] ack; int n_ins; int n_dat; logic [31:0] a0; logic [31:0] d0; logic [31:0] a1; bit err;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, rx_rd = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [31:0] insn_addr, insn_din, data_addr, data_din;
    logic insn_we, data_we, run, ack_valid, busy, err;
    logic [7:0] ack_byte;

    int cyc = 0, checks = 0, failures = 0, ack_cyc = 0;
    logic ack_run = 1'b0, exp_run = 1'b0;
    wr_t wr_q[$];
    logic [7:0] ack_q[$];
    int acc_cyc[$];
    wq_t none;

    uart_loader #(.RUN_DELAY(D), .TIMEOUT_CYCLES(TO), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .rx_rd(rx_rd), .rx_byte(rx_byte),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .run(run), .ack_valid(ack_valid), .ack_byte(ack_byte), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (insn_we) wr_q.push_back('{1'b1, insn_addr, insn_din, cyc});
        if (data_we) wr_q.push_back('{1'b0, data_addr, data_din, cyc});
        if (ack_valid) begin
            ack_q.push_back(ack_byte);
            ack_cyc = cyc;
            ack_run = run;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_byte = b;
        rx_rd = 1'b1;
        acc_cyc.push_back(cyc);
        tick();
        tick();
        rx_rd = 1'b0;
        tick();
    endtask

    task automatic clear_q();
        acc_cyc.delete();
        wr_q.delete();
        ack_q.delete();
    endtask

    task automatic wait_ack(input int lim);
        for (int i = 0; i < lim && ack_q.size() == 0; i++) tick();
    endtask

    function automatic logic [7:0] got_ack();
        return ack_q.size() != 0 ? ack_q[0] : 8'h00;
    endfunction

    function automatic bq_t build(input logic [7:0] cmd, input logic [31:0] addr, input int len,
                                  input wq_t w, input bit bad);
        bq_t q;
        logic [7:0] x = 8'h00;
        q = {8'hA5, cmd};
        if (cmd == 8'h01 || cmd == 8'h02) begin
            for (int i = 0; i < 4; i++) q.push_back(addr[8*i +: 8]);
            q.push_back(len[7:0]);
            q.push_back(len[15:8]);
            if (len > MW) return q;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < 4; j++) q.push_back(w[i][8*j +: 8]);
        end else if (cmd != 8'h03 && cmd != 8'h04) begin
            return q;
        end
        if (CHK) begin
            for (int i = 1; i < q.size(); i++) x ^= q[i];
            q.push_back(bad ? x ^ 8'h5A : x);
        end
        return q;
    endfunction

    task automatic do_frame(input bq_t fr);
        clear_q();
        foreach (fr[i]) send_byte(fr[i]);
        wait_ack(30);
    endtask

    // Frame-level reference: decodes the whole byte list and predicts writes, response and run.
    task automatic check_model(input bq_t fr, input string tag);
        logic [7:0] cmd, x;
        logic [31:0] a;
        int len;
        bit nak, wr;
        wr_t e[$];
        cmd = fr[1];
        wr = cmd == 8'h01 || cmd == 8'h02;
        nak = !(cmd >= 8'h01 && cmd <= 8'h04);
        if (wr) begin
            a = {fr[5], fr[4], fr[3], fr[2]} & 32'hFFFF_FFFC;
            len = int'({fr[7], fr[6]});
            if (len > MW) nak = 1'b1;
            else for (int i = 0; i < len; i++)
                e.push_back('{cmd == 8'h01, a + 32'(4 * i),
                              {fr[11+4*i], fr[10+4*i], fr[9+4*i], fr[8+4*i]}, acc_cyc[11+4*i] + 1});
        end
        if (!nak && CHK) begin
            x = 8'h00;
            for (int i = 1; i < fr.size() - 1; i++) x ^= fr[i];
            nak = x != fr[fr.size()-1];
        end
        if (wr) exp_run = 1'b0;
        else if (!nak && cmd == 8'h03) exp_run = 1'b1;
        else if (!nak && cmd == 8'h04) exp_run = 1'b0;
        chk({tag, "_ack"}, 32'(got_ack()), 32'(nak ? NAK : ACK));
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(e.size()));
        foreach (e[i]) if (i < wr_q.size()) begin
            chk($sformatf("%s_w%0d", tag, i),
                {wr_q[i].ins ? 32'd1 : 32'd0} ^ wr_q[i].a ^ wr_q[i].d ^ 32'(wr_q[i].c),
                {e[i].ins ? 32'd1 : 32'd0} ^ e[i].a ^ e[i].d ^ 32'(e[i].c));
        end
        chk({tag, "_err"}, 32'(err), 32'(nak));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        repeat (D + 5) tick();
        chk({tag, "_run"}, 32'(run), 32'(exp_run));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    vec_t v[7];
    bq_t fr;
    int n0, n1, n2, nins, ndat;

    initial begin
        v[0] = '{8'h01, 32'h100, 2, 32'h11223344, 32'hAABBCCDD, 1'b0, ACK, 2, 0, 32'h100, 32'h11223344, 32'h104, 1'b0};
        v[1] = '{8'h02, 32'h203, 1, 32'hDEADBEEF, 32'h0, 1'b1, CHK ? NAK : ACK, 0, 1, 32'h200, 32'hDEADBEEF, 32'h0, CHK};
        v[2] = '{8'h02, 32'h10, 1, 32'h01020304, 32'h0, 1'b0, ACK, 0, 1, 32'h10, 32'h01020304, 32'h0, 1'b0};
        v[3] = '{8'h07, 32'h0, 0, 32'h0, 32'h0, 1'b0, NAK, 0, 0, 32'h0, 32'h0, 32'h0, 1'b1};
        v[4] = '{8'h01, 32'hFFFFFFFE, 2, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, ACK, 2, 0, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0, 1'b0};
        v[5] = '{8'h02, 32'h400, 0, 32'h0, 32'h0, 1'b0, ACK, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0};
        v[6] = '{8'h01, 32'h500, MW + 1, 32'h0, 32'h0, 1'b0, NAK, 0, 0, 32'h0, 32'h0, 32'h0, 1'b1};

        repeat (3) tick();
        chk("reset_ctrl", 32'({insn_we, data_we, run, ack_valid, busy, err}), 32'd0);
        chk("reset_addr", insn_addr | data_addr | insn_din | data_din | 32'(ack_byte), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);

        foreach (v[i]) begin
            do_frame(build(v[i].cmd, v[i].addr, v[i].len, '{v[i].w0, v[i].w1}, v[i].bad));
            nins = 0;
            ndat = 0;
            foreach (wr_q[k]) if (wr_q[k].ins) nins++; else ndat++;
            chk($sformatf("v%0d_ack", i), 32'(got_ack()), 32'(v[i].ack));
            chk($sformatf("v%0d_nins", i), 32'(nins), 32'(v[i].n_ins));
            chk($sformatf("v%0d_ndat", i), 32'(ndat), 32'(v[i].n_dat));
            if (wr_q.size() > 0) begin
                chk($sformatf("v%0d_a0", i), wr_q[0].a, v[i].a0);
                chk($sformatf("v%0d_d0", i), wr_q[0].d, v[i].d0);
            end
            if (wr_q.size() > 1) chk($sformatf("v%0d_a1", i), wr_q[1].a, v[i].a1);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(v[i].err));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        do_frame(build(8'h03, 32'h0, 0, none, 1'b0));
        n0 = acc_cyc[$];
        chk("run_ack", 32'(got_ack()), 32'(ACK));
        wait_until(n0 + D - 1);
        chk("run_early", 32'(run), 32'd0);
        tick();
        chk("run_rise", 32'(run), 32'd1);

        fr = build(8'h01, 32'h0, 0, none, 1'b0);
        clear_q();
        send_byte(fr[0]);
        tick();
        rx_byte = fr[1];
        rx_rd = 1'b1;
        chk("drop_before", 32'(run), 32'd1);
        tick();
        chk("drop_after", 32'(run), 32'd0);
        rx_rd = 1'b0;
        for (int i = 2; i < fr.size(); i++) send_byte(fr[i]);
        wait_ack(30);
        chk("drop_ack", 32'(got_ack()), 32'(ACK));

        do_frame(build(8'h03, 32'h0, 0, none, 1'b0));
        n1 = acc_cyc[$];
        repeat (20) tick();
        do_frame(build(8'h03, 32'h0, 0, none, 1'b0));
        n2 = acc_cyc[$];
        wait_until(n1 + D);
        chk("restart_hold", 32'(run), 32'd0);
        wait_until(n2 + D - 1);
        chk("restart_early", 32'(run), 32'd0);
        tick();
        chk("restart_rise", 32'(run), 32'd1);

        do_frame(build(8'h04, 32'h0, 0, none, 1'b0));
        chk("halt_ack", 32'(got_ack()), 32'(ACK));
        chk("halt_run_resp", 32'(ack_run), 32'd0);

        clear_q();
        send_byte(8'h00);
        send_byte(8'h5A);
        fr = build(8'h02, 32'h80, 1, '{32'h55667788}, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(fr[i]);
        n0 = acc_cyc[$];
        wait_ack(TO + 60);
        chk("to_ack", 32'(got_ack()), 32'(NAK));
        chk("to_delay", 32'(ack_cyc - n0 >= TO && ack_cyc - n0 <= TO + 2), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_nowr", 32'(wr_q.size()), 32'd0);

        clear_q();
        fr = build(8'h01, 32'h40, 1, '{32'h12345678}, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(fr[i]);
        reset = 1'b1;
        tick();
        tick();
        chk("mrst_ctrl", 32'({insn_we, data_we, run, ack_valid, busy, err}), 32'd0);
        chk("mrst_addr", insn_addr | data_addr | insn_din | data_din | 32'(ack_byte), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        chk("mrst_noack", 32'(ack_q.size() + wr_q.size()), 32'd0);
        exp_run = 1'b0;
        do_frame(fr);
        check_model(fr, "mrst_frame");

        for (int t = 0; t < 30; t++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] cmd;
            int len;
            wq_t w;
            cmd = r < 4 ? 8'h01 : r < 6 ? 8'h02 : r == 6 ? 8'h03 : r == 7 ? 8'h04 :
                  r == 8 ? 8'($urandom_range(5, 255)) : 8'h01;
            len = r == 9 ? MW + 1 + $urandom_range(0, 100) : $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) w.push_back($urandom);
            fr = build(cmd, $urandom, len, w, $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA4)));
            do_frame(fr);
            check_model(fr, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
